lsu_mem_requester: RTL and testbench

- Initiator side of the core's data-memory port: accepts one load/store per transaction from the execute stage and drives the memory-controller request bus (valid/wen/raddr/waddr/wdata/wmask, rdata return).
- Handles byte-lane alignment, write-mask generation, load extraction and sign/zero extension, misalignment detection and an ack timeout.
- Sits between the EXU/LSU pipeline register and the data-memory controller.

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_mem_requester_if.sv | 39 +++
 rtl/lsu_lane_align.sv | 30 +++
 rtl/lsu_mem_requester.sv | 111 +++++++++++
 tb/tb_lsu_mem_requester.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared LSU types: access size, requester FSM states, byte-lane masks and the
// load extract/extend helper shared with the cache path.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // Indexed by size; the illegal size 3 maps to an empty mask.
    localparam logic [3:0][3:0] LANE_MASK = {4'b0000, 4'b1111, 4'b0011, 4'b0001};

    function automatic logic access_legal(logic [1:0] addr_lo, logic [1:0] size);
        case (size)
            SZ_B:    return 1'b1;
            SZ_H:    return !addr_lo[0];
            SZ_W:    return addr_lo == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(logic [31:0] rdata, logic [1:0] addr_lo,
                                                logic [1:0] size, logic sign_ext);
        logic [31:0] sh;
        sh = rdata >> {addr_lo, 3'b000};
        case (size)
            SZ_B:    return {{24{sign_ext & sh[7]}}, sh[7:0]};
            SZ_H:    return {{16{sign_ext & sh[15]}}, sh[15:0]};
            SZ_W:    return sh;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_requester_if.sv
// Pipeline request/response and data-memory request bus of the LSU requester.
interface lsu_mem_requester_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [1:0]        req_size;
    logic              req_signed;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              mem_valid;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_raddr;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [7:0]        mem_wmask;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        input  req_valid, req_wen, req_addr, req_wdata, req_size, req_signed,
               resp_ready, mem_rdata, mem_ack,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_valid, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask
    );

    modport slave (
        output req_valid, req_wen, req_addr, req_wdata, req_size, req_signed,
               resp_ready, mem_rdata, mem_ack,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_valid, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store data/mask shift and load extract/extend.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_addr_lo,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_wdata,
    input  logic [1:0]  ld_addr_lo,
    input  logic [1:0]  ld_size,
    input  logic        ld_signed,
    input  logic [31:0] ld_rdata,
    output logic [31:0] st_data,
    output logic [7:0]  st_mask,
    output logic [31:0] ld_data
);
    logic [31:0] data_m;

    always_comb begin
        data_m = '0;
        case (st_size)
            SZ_B:    data_m = {24'b0, st_wdata[7:0]};
            SZ_H:    data_m = {16'b0, st_wdata[15:0]};
            SZ_W:    data_m = st_wdata;
            default: data_m = '0;
        endcase
        st_data = data_m << {st_addr_lo, 3'b000};
        st_mask = {4'b0000, LANE_MASK[st_size] << st_addr_lo};
        ld_data = load_extend(ld_rdata, ld_addr_lo, ld_size, ld_signed);
    end
endmodule

// File: rtl/lsu_mem_requester.sv
// Data-memory initiator: one load/store in flight, lane alignment, misalign
// detection and ack timeout; responses held until the pipeline takes them.
module lsu_mem_requester
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    lsu_mem_requester_if.master bus
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e            state;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        addr_lo;
    logic [1:0]        size;
    logic              sign_ext;
    logic              wen;
    logic [DATA_W-1:0] st_wdata;
    logic [DATA_W-1:0] ld_data;
    logic [7:0]        st_wmask;

    lsu_lane_align u_align (
        .st_addr_lo (bus.req_addr[1:0]),
        .st_size    (bus.req_size),
        .st_wdata   (bus.req_wdata),
        .ld_addr_lo (addr_lo),
        .ld_size    (size),
        .ld_signed  (sign_ext),
        .ld_rdata   (bus.mem_rdata),
        .st_data    (st_wdata),
        .st_mask    (st_wmask),
        .ld_data    (ld_data)
    );

    assign bus.req_ready = (state == S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            addr_lo        <= '0;
            size           <= '0;
            sign_ext       <= 1'b0;
            wen            <= 1'b0;
            bus.mem_valid  <= 1'b0;
            bus.mem_wen    <= 1'b0;
            bus.mem_raddr  <= '0;
            bus.mem_waddr  <= '0;
            bus.mem_wdata  <= '0;
            bus.mem_wmask  <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.req_valid) begin
                    addr_lo  <= bus.req_addr[1:0];
                    size     <= bus.req_size;
                    sign_ext <= bus.req_signed;
                    wen      <= bus.req_wen;
                    cnt      <= '0;
                    if (!access_legal(bus.req_addr[1:0], bus.req_size)) begin
                        // Rejected without touching the memory bus.
                        state          <= S_RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b1;
                        bus.resp_rdata <= '0;
                    end else begin
                        state         <= S_REQ;
                        bus.mem_valid <= 1'b1;
                        bus.mem_wen   <= bus.req_wen;
                        bus.mem_raddr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                        bus.mem_waddr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                        bus.mem_wdata <= st_wdata;
                        bus.mem_wmask <= bus.req_wen ? st_wmask : 8'h00;
                    end
                end
                S_REQ: begin
                    // Ack takes priority over a timeout expiring in the same cycle.
                    if (bus.mem_ack) begin
                        state          <= S_RESP;
                        bus.mem_valid  <= 1'b0;
                        bus.mem_wen    <= 1'b0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b0;
                        bus.resp_rdata <= wen ? '0 : ld_data;
                    end else if (TIMEOUT != 0 && cnt == CNT_W'(TIMEOUT - 1)) begin
                        state          <= S_RESP;
                        bus.mem_valid  <= 1'b0;
                        bus.mem_wen    <= 1'b0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b1;
                        bus.resp_rdata <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RESP: if (bus.resp_ready) begin
                    state          <= S_IDLE;
                    bus.resp_valid <= 1'b0;
                    cnt            <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_requester.sv
// Randomized and directed bench for lsu_mem_requester against a size/offset arithmetic model.
module tb_lsu_mem_requester;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    lsu_mem_requester_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    lsu_mem_requester #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    endfunction

    function automatic bit is_legal(input logic [31:0] a, input logic [1:0] sz);
        int nb;
        nb = nbytes(sz);
        return nb != 0 && (a % nb) == 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a,
                                               input logic [1:0] sz, input bit sgn);
        longint v;
        int nb;
        nb = nbytes(sz);
        v = (longint'(rd) >> (8 * (a % 4))) & ((64'd1 << (8 * nb)) - 1);
        if (sgn && v >= (64'd1 << (8 * nb - 1)))
            v = v - (64'd1 << (8 * nb));
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [31:0] a,
                                                input logic [1:0] sz);
        longint v;
        v = (longint'(wd) & ((64'd1 << (8 * nbytes(sz))) - 1)) << (8 * (a % 4));
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_wmask(input logic [31:0] a, input logic [1:0] sz);
        return ((32'd1 << nbytes(sz)) - 1) << (a % 4);
    endfunction

    // ack_dly: REQ cycles before the ack (0 = zero-wait), negative = never acked.
    task automatic do_txn(input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] sz, input bit sgn, input logic [31:0] rdata,
                          input int ack_dly, input int resp_dly);
        bit          legal;
        bit          exp_err;
        int          exp_n;
        int          n;
        int          wen_n;
        int          rv_n;
        logic [31:0] exp_rd;
        logic [31:0] held_rd;
        logic        held_err;

        legal   = is_legal(addr, sz);
        exp_err = !legal || ack_dly < 0 || ack_dly >= TMO;
        exp_n   = !legal ? 0 : (ack_dly < 0 || ack_dly >= TMO) ? TMO : ack_dly + 1;
        exp_rd  = (exp_err || wen) ? 32'h0 : model_load(rdata, addr, sz, sgn);

        check_eq("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_wen    = wen;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_size   = sz;
        bus.req_signed = sgn;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;

        n = 0;
        wen_n = 0;
        while (bus.mem_valid && n < 40) begin
            n++;
            if (bus.mem_wen) wen_n++;
            if (n == 1) begin
                check_eq("mem_raddr", bus.mem_raddr, addr & ~32'h3);
                check_eq("mem_waddr", bus.mem_waddr, addr & ~32'h3);
                check_eq("mem_wmask", 32'(bus.mem_wmask), wen ? model_wmask(addr, sz) : 32'h0);
                if (wen) check_eq("mem_wdata", bus.mem_wdata, model_wdata(wdata, addr, sz));
            end
            check_eq("req_ready_busy", 32'(bus.req_ready), 32'd0);
            check_eq("resp_valid_in_req", 32'(bus.resp_valid), 32'd0);
            if (n - 1 == ack_dly) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = rdata;
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = $urandom;
            end
            @(posedge clk); #1;
        end
        bus.mem_ack = 1'b0;
        check_eq("mem_valid_cycles", 32'(n), 32'(exp_n));
        check_eq("mem_wen_cycles", 32'(wen_n), wen ? 32'(exp_n) : 32'd0);

        held_rd  = bus.resp_rdata;
        held_err = bus.resp_err;
        check_eq("resp_rdata", held_rd, exp_rd);
        check_eq("resp_err", 32'(held_err), 32'(exp_err));
        rv_n = 0;
        for (int i = 0; i <= resp_dly; i++) begin
            if (bus.resp_valid) rv_n++;
            check_eq("resp_rdata_stable", bus.resp_rdata, held_rd);
            check_eq("resp_err_stable", 32'(bus.resp_err), 32'(held_err));
            check_eq("mem_valid_in_resp", 32'(bus.mem_valid), 32'd0);
            check_eq("req_ready_in_resp", 32'(bus.req_ready), 32'd0);
            if (i == resp_dly) bus.resp_ready = 1'b1;
            @(posedge clk); #1;
        end
        bus.resp_ready = 1'b0;
        check_eq("resp_valid_cycles", 32'(rv_n), 32'(resp_dly + 1));
        check_eq("resp_valid_after", 32'(bus.resp_valid), 32'd0);
        check_eq("mem_wen_idle", 32'(bus.mem_wen), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_wen    = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_size   = '0;
        bus.req_signed = 1'b0;
        bus.resp_ready = 1'b0;
        bus.mem_rdata  = '0;
        bus.mem_ack    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        check_eq("rst_mem_wen", 32'(bus.mem_wen), 32'd0);
        check_eq("rst_mem_raddr", bus.mem_raddr, 32'd0);
        check_eq("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check_eq("rst_mem_wmask", 32'(bus.mem_wmask), 32'd0);
        check_eq("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check_eq("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check_eq("rst_resp_err", 32'(bus.resp_err), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_req_ready", 32'(bus.req_ready), 32'd1);

        // Directed cases.
        do_txn(1'b1, 32'h8000_0003, 32'h0000_00AB, 2'd0, 1'b0, 32'h0, 0, 0);
        do_txn(1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b1, 32'h8001_1234, 0, 0);
        do_txn(1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b0, 32'h8001_1234, 0, 0);
        do_txn(1'b0, 32'h8000_0001, 32'h0, 2'd2, 1'b0, 32'hDEAD_BEEF, 0, 0);
        do_txn(1'b1, 32'h8000_0010, 32'h0, 2'd3, 1'b0, 32'h0, 0, 1);
        do_txn(1'b0, 32'h8000_0004, 32'h0, 2'd2, 1'b0, 32'h1234_5678, 5, 3);
        do_txn(1'b0, 32'h8000_0008, 32'h0, 2'd2, 1'b0, 32'hCAFE_F00D, -1, 0);
        do_txn(1'b0, 32'h8000_0008, 32'h0, 2'd2, 1'b0, 32'hCAFE_F00D, TMO - 1, 0);
        do_txn(1'b1, 32'h8000_0006, 32'h5555_BEEF, 2'd1, 1'b0, 32'h0, 2, 0);

        // Reset during a pending load.
        bus.req_valid  = 1'b1;
        bus.req_wen    = 1'b0;
        bus.req_addr   = 32'h8000_0020;
        bus.req_size   = 2'd2;
        bus.req_signed = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check_eq("mid_rst_mem_valid_before", 32'(bus.mem_valid), 32'd1);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        check_eq("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check_eq("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
        check_eq("mid_rst_resp_idle", 32'(bus.resp_valid), 32'd0);
        do_txn(1'b0, 32'h8000_0021, 32'h0, 2'd0, 1'b1, 32'h0000_F000, 1, 0);

        // Randomized traffic, mostly legal with short waits.
        for (int t = 0; t < 80; t++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            int          dly;
            sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a   = $urandom;
            if ($urandom_range(0, 3) != 0)
                a = a & ~(32'(nbytes(sz == 2'd3 ? 2'd0 : sz)) - 32'd1);
            dly = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TMO + 2) - 1
                                              : $urandom_range(0, 3);
            do_txn(1'($urandom), a, $urandom, sz, 1'($urandom), $urandom, dly,
                   $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
